zeroriscy_vector_ex_stage: RTL and testbench

- Vector execute stage feeding the 4-lane vector ALU (`zeroriscy_vector_alu`) and writing its result back into a local 8-entry vector register file.
- Contents of each stage:
  - 8 x 4 x 32-bit vector register file.
  - Operand-fetch register, with an optional scalar broadcast on operand B.
  - Result/writeback register.
  - Full forwarding, so back-to-back dependent ops never stall.
- An external load port fills registers, and a read port exposes architectural state to the LSU/debug.

---
 rtl/zeroriscy_vector_ex_stage_if.sv | 49 ++++
 rtl/zeroriscy_vector_ex_stage.sv | 111 +++++++++++
 tb/tb_zeroriscy_vector_ex_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_vector_ex_stage_if.sv
// rtl/zeroriscy_vector_ex_stage_if.sv - issue, ALU, load, read and writeback signals of the vector execute stage
interface zeroriscy_vector_ex_stage_if #(
  parameter int NREGS  = 8,
  parameter int NLANES = 4
);
  localparam int RW = $clog2(NREGS);

  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_opcode;
  logic [RW-1:0]            in_vd;
  logic [RW-1:0]            in_vs1;
  logic [RW-1:0]            in_vs2;
  logic                     in_bsel;
  logic [31:0]              in_scalar;

  logic [NLANES-1:0][31:0]  alu_arg_a;
  logic [NLANES-1:0][31:0]  alu_arg_b;
  logic [3:0]               alu_opcode;
  logic [NLANES-1:0][31:0]  alu_res;

  logic                     ext_we;
  logic                     ext_ready;
  logic [RW-1:0]            ext_vd;
  logic [NLANES-1:0][31:0]  ext_data;

  logic [RW-1:0]            rd_vs;
  logic [NLANES-1:0][31:0]  rd_data;

  logic                     wb_valid;
  logic [RW-1:0]            wb_vd;
  logic [NLANES-1:0][31:0]  wb_data;
  logic                     err;
  logic                     busy;

  modport master (
    output in_valid, in_opcode, in_vd, in_vs1, in_vs2, in_bsel, in_scalar,
    output alu_res, ext_we, ext_vd, ext_data, rd_vs,
    input  in_ready, alu_arg_a, alu_arg_b, alu_opcode, ext_ready, rd_data,
    input  wb_valid, wb_vd, wb_data, err, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_vd, in_vs1, in_vs2, in_bsel, in_scalar,
    input  alu_res, ext_we, ext_vd, ext_data, rd_vs,
    output in_ready, alu_arg_a, alu_arg_b, alu_opcode, ext_ready, rd_data,
    output wb_valid, wb_vd, wb_data, err, busy
  );
endinterface

// File: rtl/zeroriscy_vector_ex_stage.sv
// rtl/zeroriscy_vector_ex_stage.sv - vector execute stage: regfile, operand fetch with forwarding, writeback
module zeroriscy_vector_ex_stage #(
  parameter int NREGS  = 8,
  parameter int NLANES = 4
) (
  input logic                      clk,
  input logic                      rst,
  zeroriscy_vector_ex_stage_if.slave vif
);
  localparam int RW = $clog2(NREGS);
  typedef logic [NLANES-1:0][31:0] vec_t;

  vec_t          rf [NREGS];

  logic          op_valid;
  logic          op_legal;
  logic [3:0]    op_opcode;
  logic [RW-1:0] op_vd;
  vec_t          op_a;
  vec_t          op_b;

  logic          wb_v;
  logic          wb_legal;
  logic [RW-1:0] wb_vd_q;
  vec_t          wb_data_q;

  logic          accept;
  logic          ext_go;
  logic          wb_write;
  logic          in_legal;
  vec_t          src_a;
  vec_t          src_b;

  // Youngest legal producer wins: op stage (still in the ALU), then writeback, then the regfile.
  function automatic vec_t fetch(input logic [RW-1:0] vs,
                                 input logic op_fwd, input logic [RW-1:0] op_dst, input vec_t op_res,
                                 input logic wb_fwd, input logic [RW-1:0] wb_dst, input vec_t wb_res,
                                 input vec_t rf_val);
    if (op_fwd && op_dst == vs)
      return op_res;
    else if (wb_fwd && wb_dst == vs)
      return wb_res;
    else
      return rf_val;
  endfunction

  assign wb_write      = wb_v & wb_legal;
  assign accept        = vif.in_valid & ~vif.ext_we;
  assign ext_go        = vif.ext_we & ~op_valid & ~wb_write;
  assign in_legal      = (vif.in_opcode <= 4'd4);

  assign vif.in_ready   = ~vif.ext_we;
  assign vif.ext_ready  = ext_go;
  assign vif.alu_arg_a  = op_a;
  assign vif.alu_arg_b  = op_b;
  assign vif.alu_opcode = op_opcode;
  assign vif.rd_data    = rf[vif.rd_vs];
  assign vif.wb_valid   = wb_write;
  assign vif.wb_vd      = wb_vd_q;
  assign vif.wb_data    = wb_data_q;
  assign vif.err        = wb_v & ~wb_legal;
  assign vif.busy       = op_valid | wb_write;

  always_comb begin
    src_a = fetch(vif.in_vs1, op_valid & op_legal, op_vd, vif.alu_res,
                  wb_write, wb_vd_q, wb_data_q, rf[vif.in_vs1]);
    src_b = fetch(vif.in_vs2, op_valid & op_legal, op_vd, vif.alu_res,
                  wb_write, wb_vd_q, wb_data_q, rf[vif.in_vs2]);
    if (vif.in_bsel)
      src_b = {NLANES{vif.in_scalar}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
      op_valid  <= 1'b0;
      op_legal  <= 1'b0;
      op_opcode <= '0;
      op_vd     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      wb_v      <= 1'b0;
      wb_legal  <= 1'b0;
      wb_vd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      // ext_go excludes a pending writeback, so the two regfile writes never collide.
      if (wb_write)
        rf[wb_vd_q] <= wb_data_q;
      else if (ext_go)
        rf[vif.ext_vd] <= vif.ext_data;

      op_valid <= accept;
      if (accept) begin
        op_legal  <= in_legal;
        op_opcode <= vif.in_opcode;
        op_vd     <= vif.in_vd;
        op_a      <= src_a;
        op_b      <= src_b;
      end

      wb_v <= op_valid;
      if (op_valid) begin
        wb_legal  <= op_legal;
        wb_vd_q   <= op_vd;
        wb_data_q <= vif.alu_res;
      end
    end
  end
endmodule

// File: tb/tb_zeroriscy_vector_ex_stage.sv
// tb/tb_zeroriscy_vector_ex_stage.sv - randomized and directed check of the vector execute stage against a sequential model
module tb_zeroriscy_vector_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zeroriscy_vector_ex_stage_if vif ();

  zeroriscy_vector_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  int vectors = 0;
  int miscompares = 0;
  int wb_seen = 0;
  int err_seen = 0;
  bit ext_acc;

  function automatic logic [31:0] lane_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return a >> b[4:0];
      4'd4: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [127:0] vec_alu(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      r[l*32 +: 32] = lane_alu(op, a[l*32 +: 32], b[l*32 +: 32]);
    return r;
  endfunction

  // External ALU: combinational, lane-wise, garbage on illegal opcodes.
  always_comb begin
    vif.alu_res = '0;
    for (int l = 0; l < 4; l++)
      vif.alu_res[l] = lane_alu(vif.alu_opcode, vif.alu_arg_a[l], vif.alu_arg_b[l]);
  end

  // Model: spec_rf holds program-order state (every accepted op applied at once);
  // arch_rf holds what the regfile must contain; p1/p2 are the ops in flight.
  typedef struct {
    bit           v;
    bit           legal;
    logic [2:0]   vd;
    logic [3:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] res;
  } ent_t;

  logic [127:0] spec_rf [8];
  logic [127:0] arch_rf [8];
  ent_t p1, p2;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      spec_rf[i] = '0;
      arch_rf[i] = '0;
    end
    p1 = '{default: '0};
    p2 = '{default: '0};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model, return at posedge+1.
  task automatic cyc();
    bit exp_er, exp_wbv, exp_err, acc;
    ent_t n;
    @(negedge clk);
    exp_wbv = p2.v && p2.legal;
    exp_err = p2.v && !p2.legal;
    exp_er  = vif.ext_we && !p1.v && !exp_wbv;
    chk("in_ready", vif.in_ready, !vif.ext_we);
    chk("ext_ready", vif.ext_ready, exp_er);
    chk("wb_valid", vif.wb_valid, exp_wbv);
    chk("err", vif.err, exp_err);
    chk("busy", vif.busy, p1.v || exp_wbv);
    if (p2.v) chk("wb_vd", vif.wb_vd, p2.vd);
    if (exp_wbv) chk("wb_data", vif.wb_data, p2.res);
    if (p1.v) begin
      chk("alu_opcode", vif.alu_opcode, p1.op);
      chk("alu_arg_a", vif.alu_arg_a, p1.a);
      chk("alu_arg_b", vif.alu_arg_b, p1.b);
    end
    chk("rd_data", vif.rd_data, arch_rf[vif.rd_vs]);
    if (vif.wb_valid) wb_seen++;
    if (vif.err) err_seen++;

    if (exp_wbv) arch_rf[p2.vd] = p2.res;
    ext_acc = exp_er;
    if (exp_er) begin
      arch_rf[vif.ext_vd] = vif.ext_data;
      spec_rf[vif.ext_vd] = vif.ext_data;
    end
    acc = vif.in_valid && !vif.ext_we;
    n = '{default: '0};
    if (acc) begin
      n.v     = 1'b1;
      n.legal = (vif.in_opcode <= 4'd4);
      n.vd    = vif.in_vd;
      n.op    = vif.in_opcode;
      n.a     = spec_rf[vif.in_vs1];
      n.b     = vif.in_bsel ? {4{vif.in_scalar}} : spec_rf[vif.in_vs2];
      n.res   = vec_alu(n.op, n.a, n.b);
      if (n.legal) spec_rf[n.vd] = n.res;
    end
    p2 = p1;
    p1 = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] vd, input logic [2:0] vs1,
                       input logic [2:0] vs2, input logic bsel, input logic [31:0] scalar);
    vif.in_opcode = op;
    vif.in_vd     = vd;
    vif.in_vs1    = vs1;
    vif.in_vs2    = vs2;
    vif.in_bsel   = bsel;
    vif.in_scalar = scalar;
    vif.in_valid  = 1'b1;
    cyc();
    vif.in_valid  = 1'b0;
  endtask

  task automatic ext_load(input logic [2:0] vd, input logic [127:0] data, output int waits);
    vif.ext_we   = 1'b1;
    vif.ext_vd   = vd;
    vif.ext_data = data;
    waits   = 0;
    ext_acc = 1'b0;
    while (!ext_acc && waits < 20) begin
      cyc();
      waits++;
    end
    if (!ext_acc) chk("ext_timeout", 1'b0, 1'b1);
    vif.ext_we = 1'b0;
  endtask

  task automatic rd_lit(input string nm, input logic [2:0] vs, input logic [127:0] lit);
    vif.rd_vs = vs;
    #1;
    chk(nm, vif.rd_data, lit);
  endtask

  initial begin
    int w, e0;
    bit stalled;
    vif.in_valid = 0; vif.in_opcode = 0; vif.in_vd = 0; vif.in_vs1 = 0; vif.in_vs2 = 0;
    vif.in_bsel = 0; vif.in_scalar = 0; vif.ext_we = 0; vif.ext_vd = 0; vif.ext_data = '0;
    vif.rd_vs = 0;
    model_reset();
    #1;
    chk("rst_wb_valid", vif.wb_valid, 1'b0);
    chk("rst_err", vif.err, 1'b0);
    chk("rst_busy", vif.busy, 1'b0);
    chk("rst_wb_data", vif.wb_data, '0);
    chk("rst_alu_a", vif.alu_arg_a, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add
    ext_load(3'd1, 128'h00000004_00000003_00000002_00000001, w);
    ext_load(3'd2, 128'h00000028_0000001E_00000014_0000000A, w);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
    idle(3);
    rd_lit("add_v3", 3'd3, 128'h0000002C_00000021_00000016_0000000B);

    // Back-to-back RAW chain
    ext_load(3'd1, {4{32'd5}}, w);
    ext_load(3'd2, {4{32'd1}}, w);
    w = wb_seen;
    issue(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
    issue(4'd1, 3'd3, 3'd3, 3'd2, 1'b0, 32'd0);
    issue(4'd1, 3'd3, 3'd3, 3'd2, 1'b0, 32'd0);
    idle(3);
    chk("raw_wb_count", wb_seen - w, 3);
    rd_lit("raw_v3", 3'd3, {4{32'd2}});

    // Scalar broadcast shifts
    ext_load(3'd1, 128'hFFFFFFFF_00000001_000000F0_80000000, w);
    issue(4'd4, 3'd2, 3'd1, 3'd7, 1'b1, 32'h24);
    issue(4'd3, 3'd3, 3'd1, 3'd7, 1'b1, 32'h24);
    idle(3);
    rd_lit("sra_v2", 3'd2, 128'hFFFFFFFF_00000000_0000000F_F8000000);
    rd_lit("srl_v3", 3'd3, 128'h0FFFFFFF_00000000_0000000F_08000000);

    // Illegal opcode followed by a dependent add
    e0 = err_seen;
    issue(4'd7, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0);
    issue(4'd0, 3'd5, 3'd4, 3'd4, 1'b0, 32'd0);
    idle(3);
    chk("illegal_err_count", err_seen - e0, 1);
    rd_lit("illegal_v4", 3'd4, '0);
    rd_lit("illegal_v5", 3'd5, '0);

    // Arbitration: external write waits for the pipeline to drain, instruction waits for ext_we
    issue(4'd0, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0);
    vif.in_opcode = 4'd1; vif.in_vd = 3'd7; vif.in_vs1 = 3'd6; vif.in_vs2 = 3'd1;
    vif.in_bsel = 1'b0; vif.in_valid = 1'b1;
    ext_load(3'd0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, w);
    chk("arb_wait_cycles", w, 3);
    cyc();
    vif.in_valid = 1'b0;
    idle(3);
    rd_lit("arb_v0", 3'd0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

    // Randomized traffic
    stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        vif.in_valid  = ($urandom_range(0, 3) != 0);
        vif.in_opcode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
        vif.in_vd     = 3'($urandom);
        vif.in_vs1    = 3'($urandom);
        vif.in_vs2    = 3'($urandom);
        vif.in_bsel   = ($urandom_range(0, 3) == 0);
        vif.in_scalar = $urandom;
      end
      vif.ext_we   = ($urandom_range(0, 7) == 0);
      vif.ext_vd   = 3'($urandom);
      vif.ext_data = {$urandom, $urandom, $urandom, $urandom};
      vif.rd_vs    = 3'($urandom);
      stalled = vif.in_valid && vif.ext_we;
      cyc();
    end
    vif.in_valid = 1'b0;
    vif.ext_we   = 1'b0;
    idle(3);

    // Reset in the cycle after an accept
    w = wb_seen;
    e0 = err_seen;
    issue(4'd0, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_wb_valid", vif.wb_valid, 1'b0);
    chk("midrst_busy", vif.busy, 1'b0);
    chk("midrst_alu_b", vif.alu_arg_b, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk("midrst_no_wb", wb_seen - w, 0);
    chk("midrst_no_err", err_seen - e0, 0);
    for (int r = 0; r < 8; r++)
      rd_lit("midrst_reg", 3'(r), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
